// File: rtl/clk_div_int.sv
// Integer clock divider: o_div_clk is CLK divided by a runtime ratio, with CLK passed
// straight through for ratios 0/1 or when disabled. o_period_tick marks each period end.
module clk_div_int #(
   parameter int div_ratio_width = 8
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       clk_div_en,
   input  logic [div_ratio_width-1:0] i_div_ratio,
   output logic                       o_div_clk,
   output logic                       o_period_tick
);
   localparam int W = div_ratio_width;

   typedef enum logic {PH_LOW = 1'b0, PH_HIGH = 1'b1} phase_e;

   phase_e         div_clk_reg, div_clk_nxt;
   logic [W-1:0]   counter, counter_nxt;
   logic [W-1:0]   ratio_q, ratio_nxt;
   logic           tick_nxt;
   logic [W:0]     ratio_p1;
   logic [W-1:0]   low_len, high_len;
   logic           bypass;

   // N+1 needs the extra bit so N=2^W-1 still yields a LOW phase of 2^(W-1).
   assign ratio_p1 = {1'b0, ratio_q} + {{W{1'b0}}, 1'b1};
   assign low_len  = ratio_p1[W:1];
   assign high_len = ratio_q >> 1;
   assign bypass   = !clk_div_en || (ratio_q <= W'(1));

   always_comb begin
      div_clk_nxt = div_clk_reg;
      counter_nxt = counter;
      ratio_nxt   = ratio_q;
      tick_nxt    = 1'b0;
      if (bypass) begin
         div_clk_nxt = PH_LOW;
         counter_nxt = '0;
         ratio_nxt   = i_div_ratio;
      end else begin
         unique case (div_clk_reg)
            PH_LOW: begin
               if (counter == low_len - W'(1)) begin
                  div_clk_nxt = PH_HIGH;
                  counter_nxt = '0;
               end else begin
                  counter_nxt = counter + W'(1);
               end
            end
            PH_HIGH: begin
               // The ratio only changes here, so a running period is never cut short.
               if (counter == high_len - W'(1)) begin
                  div_clk_nxt = PH_LOW;
                  counter_nxt = '0;
                  tick_nxt    = 1'b1;
                  ratio_nxt   = i_div_ratio;
               end else begin
                  counter_nxt = counter + W'(1);
               end
            end
            default: begin
               div_clk_nxt = PH_LOW;
               counter_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         div_clk_reg   <= PH_LOW;
         counter       <= '0;
         ratio_q       <= '0;
         o_period_tick <= 1'b0;
      end else begin
         div_clk_reg   <= div_clk_nxt;
         counter       <= counter_nxt;
         ratio_q       <= ratio_nxt;
         o_period_tick <= tick_nxt;
      end
   end

   assign o_div_clk = bypass ? CLK : (div_clk_reg == PH_HIGH);

endmodule

// File: tb/tb_clk_div_int.sv
// Randomised and directed bench for clk_div_int against a period-position model.
module tb_clk_div_int;
   localparam int W = 8;

   logic         CLK = 1'b0;
   logic         RST = 1'b0;
   logic         en = 1'b0;
   logic [W-1:0] ratio = '0;
   logic         o_div_clk;
   logic         o_period_tick;

   always #5 CLK = ~CLK;

   clk_div_int #(.div_ratio_width(W)) dut (
      .CLK(CLK), .RST(RST), .clk_div_en(en), .i_div_ratio(ratio),
      .o_div_clk(o_div_clk), .o_period_tick(o_period_tick)
   );

   // Model: m_n is the ratio in force, m_p the number of CLK edges into the current period.
   int m_n = 0;
   int m_p = 0;
   bit m_tick = 1'b0;

   function automatic int low_of(input int n);
      return (n + 1) / 2;
   endfunction

   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         m_n <= 0; m_p <= 0; m_tick <= 1'b0;
      end else if (!en || m_n <= 1) begin
         m_n <= int'(ratio); m_p <= 0; m_tick <= 1'b0;
      end else if (m_p + 1 == m_n) begin
         m_n <= int'(ratio); m_p <= 0; m_tick <= 1'b1;
      end else begin
         m_p <= m_p + 1; m_tick <= 1'b0;
      end
   end

   int ncmp = 0;
   int nerr = 0;
   int exp_period = 0;
   int exp_high = 0;
   bit tmo = 1'b0;

   task automatic chk(input string name, input int act, input int expv);
      ncmp++;
      if (act != expv) begin
         nerr++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
      end
   endtask

   // Single compare process: every half cycle against the model, plus period/high-time
   // literals whenever the stimulus has armed them.
   initial begin
      int  cyc = 0;
      int  hi = 0;
      bit  tmo_seen = 1'b0;
      int  expc;
      forever begin
         @(posedge CLK); #1;
         expc = (!en || m_n <= 1) ? 1 : int'(m_p >= low_of(m_n));
         chk("div_clk_hi_half", int'(o_div_clk), expc);
         chk("period_tick", int'(o_period_tick), int'(m_tick));
         cyc++;
         if (o_div_clk) hi++;
         if (o_period_tick) begin
            if (exp_period != 0) begin
               chk("period_len", cyc, exp_period);
               chk("high_len", hi, exp_high);
            end
            cyc = 0; hi = 0;
         end
         if (tmo && !tmo_seen) begin
            tmo_seen = 1'b1;
            chk("tick_wait_timeout", int'(tmo), 0);
         end
         @(negedge CLK); #1;
         expc = (!en || m_n <= 1) ? 0 : int'(m_p >= low_of(m_n));
         chk("div_clk_lo_half", int'(o_div_clk), expc);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #3;
   endtask

   task automatic wait_tick();
      for (int i = 0; i < 600; i++) begin
         @(posedge CLK); #2;
         if (o_period_tick) return;
      end
      tmo = 1'b1;
   endtask

   task automatic arm(input int p, input int h);
      exp_period = p;
      exp_high = h;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int r;
      // N=4 straight out of reset
      en = 1'b1; ratio = 8'd4;
      step(3);
      RST = 1'b1;
      wait_tick();
      arm(4, 2);
      repeat (4) wait_tick();
      // N=5
      ratio = 8'd5;
      wait_tick();
      arm(5, 2);
      repeat (10) wait_tick();
      // bypass cases: N=1, N=0, en=0 with N=8
      arm(0, 0);
      ratio = 8'd1;
      wait_tick();
      step(20);
      ratio = 8'd0;
      step(20);
      ratio = 8'd8; en = 1'b0;
      step(20);
      // N=8 with mid-period change to 6
      en = 1'b1;
      wait_tick();
      arm(8, 4);
      wait_tick();
      repeat (3) @(posedge CLK);
      #3 ratio = 8'd6;
      wait_tick();
      arm(6, 3);
      repeat (3) wait_tick();
      // N=255
      arm(0, 0);
      ratio = 8'd255;
      wait_tick();
      arm(255, 127);
      repeat (2) wait_tick();
      // N=6: drop enable mid-HIGH, then reassert
      arm(0, 0);
      ratio = 8'd6;
      wait_tick();
      wait_tick();
      step(4);
      en = 1'b0;
      step(5);
      en = 1'b1;
      wait_tick();
      arm(6, 3);
      wait_tick();
      arm(0, 0);
      // async reset mid-LOW, then mid-HIGH
      step(1);
      RST = 1'b0;
      step(2);
      RST = 1'b1;
      wait_tick();
      wait_tick();
      step(4);
      RST = 1'b0;
      step(2);
      RST = 1'b1;
      wait_tick();
      arm(6, 3);
      wait_tick();
      arm(0, 0);
      // random phase
      for (int i = 0; i < 4000; i++) begin
         step(1);
         r = int'($urandom_range(0, 99));
         if (r < 3) en = ~en;
         else if (r < 6) ratio = W'($urandom_range(0, 12));
         else if (r < 7) ratio = W'($urandom_range(0, 255));
         else if (r == 7) RST = 1'b0;
         else if (r < 20) RST = 1'b1;
      end
      RST = 1'b1;
      step(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
